// File: rtl/multdiv_step_counter.sv
// multdiv_step_counter: iteration sequencer stepping a count 0..LAST for the multi-cycle multiply/divide unit
module multdiv_step_counter #(
  parameter int WIDTH = 5,
  parameter int LAST  = 31
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             kill,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);
  if (WIDTH < 1 || WIDTH > 30 || LAST < 0 || LAST > (2 ** WIDTH) - 1) begin : g_bad_params
    $error("multdiv_step_counter: LAST=%0d out of range for WIDTH=%0d", LAST, WIDTH);
  end
  localparam logic [WIDTH-1:0] LAST_C = WIDTH'(LAST);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  // kill beats start beats stall beats step; anything but RUN/start falls back to IDLE with count 0
  always_comb begin
    state_nx = IDLE;
    count_nx = '0;
    if (!kill && start) state_nx = RUN;
    else if (!kill && state == RUN) begin
      state_nx = (stall || count != LAST_C) ? RUN : DONE;
      count_nx = (stall || count == LAST_C) ? count : count + WIDTH'(1);
    end
  end
  // outputs are registered from the next state/count so they carry no path from the inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      last  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      busy  <= state_nx == RUN;
      last  <= state_nx == RUN && count_nx == LAST_C;
      done  <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_multdiv_step_counter.sv
// tb_multdiv_step_counter: directed checks of the step counter (LAST=31 and LAST=0 instances)
module tb_multdiv_step_counter;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 1'b0, stall_a = 1'b0, kill_a = 1'b0;
  logic       start_b = 1'b0, stall_b = 1'b0, kill_b = 1'b0;
  logic [4:0] count_a;
  logic [2:0] count_b;
  logic       busy_a, last_a, done_a, busy_b, last_b, done_b;
  int         n_checks = 0;
  int         n_fail = 0;

  multdiv_step_counter #(.WIDTH(5), .LAST(31)) u_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .stall(stall_a), .kill(kill_a),
    .count(count_a), .busy(busy_a), .last(last_a), .done(done_a)
  );
  multdiv_step_counter #(.WIDTH(3), .LAST(0)) u_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .stall(stall_b), .kill(kill_b),
    .count(count_b), .busy(busy_b), .last(last_b), .done(done_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic pulse_a();
    @(negedge clock);
    start_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0;
  endtask

  task automatic pulse_b(input logic with_kill);
    @(negedge clock);
    start_b = 1'b1;
    kill_b  = with_kill;
    @(posedge clock);
    #1 start_b = 1'b0;
    kill_b = 1'b0;
  endtask

  // expected outputs in cycle c of an unstalled LAST=31 run (cycle 1 follows the start edge)
  task automatic plain_a(input string t, input int c);
    check($sformatf("%s.c%0d.busy", t, c), busy_a, c <= 32);
    check($sformatf("%s.c%0d.count", t, c), count_a, c <= 32 ? c - 1 : c == 33 ? 31 : 0);
    check($sformatf("%s.c%0d.last", t, c), last_a, c == 32);
    check($sformatf("%s.c%0d.done", t, c), done_a, c == 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset.count", count_a, 0);
    check("reset.busy", busy_a, 0);
    check("reset.last", last_a, 0);
    check("reset.done", done_a, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle.busy", busy_a, 0);
    // 1: plain run
    pulse_a();
    for (int c = 1; c <= 34; c++) begin
      @(negedge clock);
      plain_a("t1", c);
    end
    // 2: stall for three cycles while count=5
    pulse_a();
    for (int c = 1; c <= 37; c++) begin
      @(negedge clock);
      check($sformatf("t2.c%0d.busy", c), busy_a, c <= 35);
      check($sformatf("t2.c%0d.count", c), count_a,
            c <= 6 ? c - 1 : c <= 9 ? 5 : c <= 35 ? c - 4 : c == 36 ? 31 : 0);
      check($sformatf("t2.c%0d.last", c), last_a, c == 35);
      check($sformatf("t2.c%0d.done", c), done_a, c == 36);
      stall_a = c >= 6 && c <= 8;
    end
    stall_a = 1'b0;
    // 3: kill at count=10
    pulse_a();
    for (int c = 1; c <= 11; c++) @(negedge clock);
    check("t3.count_before", count_a, 10);
    kill_a = 1'b1;
    @(negedge clock);
    kill_a = 1'b0;
    check("t3.busy_after", busy_a, 0);
    check("t3.count_after", count_a, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      check($sformatf("t3.c%0d.done", c), done_a, 0);
      check($sformatf("t3.c%0d.busy", c), busy_a, 0);
    end
    // 4: back-to-back run via start in the DONE cycle
    pulse_a();
    for (int c = 1; c <= 33; c++) begin
      @(negedge clock);
      plain_a("t4a", c);
    end
    start_a = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      plain_a("t4b", c);
    end
    // 5: asynchronous reset at count=17
    pulse_a();
    for (int c = 1; c <= 18; c++) @(negedge clock);
    check("t5.count_before", count_a, 17);
    #2 reset_n = 1'b0;
    #1;
    check("t5.count_async", count_a, 0);
    check("t5.busy_async", busy_a, 0);
    check("t5.done_async", done_a, 0);
    check("t5.last_async", last_a, 0);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("t5.idle%0d.busy", c), busy_a, 0);
      check($sformatf("t5.idle%0d.count", c), count_a, 0);
    end
    pulse_a();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      plain_a("t5r", c);
    end
    // 6: LAST=0 instance
    pulse_b(1'b0);
    @(negedge clock);
    check("t6.c1.busy", busy_b, 1);
    check("t6.c1.last", last_b, 1);
    check("t6.c1.count", count_b, 0);
    check("t6.c1.done", done_b, 0);
    @(negedge clock);
    check("t6.c2.busy", busy_b, 0);
    check("t6.c2.last", last_b, 0);
    check("t6.c2.done", done_b, 1);
    @(negedge clock);
    check("t6.c3.done", done_b, 0);
    check("t6.c3.busy", busy_b, 0);
    pulse_b(1'b1);
    @(negedge clock);
    check("t6.startkill.busy", busy_b, 0);
    check("t6.startkill.done", done_b, 0);
    check("t6.startkill.count", count_b, 0);
    pulse_b(1'b0);
    @(negedge clock);
    @(negedge clock);
    check("t6.killdone.done", done_b, 1);
    start_b = 1'b1;
    kill_b  = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    kill_b  = 1'b0;
    check("t6.killdone.busy_next", busy_b, 0);
    check("t6.killdone.done_next", done_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
